bluetooth_send_ctrl: RTL and testbench



---
 rtl/bluetooth_send_ctrl.sv | 68 ++++++
 tb/tb_bluetooth_send_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bluetooth_send_ctrl.sv
// bluetooth_send_ctrl: byte FIFO that replays a requested frame to a UART transmitter
module bluetooth_send_ctrl #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_pulse,
    input  logic [7:0]        rx_data,
    input  logic              tx_en,
    input  logic [15:0]       data_length,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              send_done,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow
);
    localparam int CW = ADDR_W + 1;
    typedef enum logic [1:0] {IDLE, RD, LD, WAIT} state_t;
    state_t state, state_n;
    logic [7:0] mem [DEPTH];
    logic [7:0] ram_q;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] remain, len;
    logic wr_ok, commit, last, empty_req;
    always_comb begin
        wr_ok = wr_pulse && fifo_count != CW'(DEPTH);
        commit = state == WAIT && tx_done;
        last = commit && remain == CW'(1);
        len = data_length < 16'(fifo_count) ? CW'(data_length) : fifo_count;
        empty_req = state == IDLE && tx_en && len == '0;
        state_n = state == IDLE ? ((tx_en && len != '0) ? RD : IDLE) :
                  state == RD   ? LD :
                  state == LD   ? WAIT :
                  commit        ? (last ? IDLE : RD) : WAIT;
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= rx_data;
        ram_q <= mem[rd_ptr];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            remain     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            send_done  <= 1'b0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr + ADDR_W'(wr_ok);
            rd_ptr     <= rd_ptr + ADDR_W'(commit);
            fifo_count <= fifo_count + CW'(wr_ok) - CW'(commit);
            overflow   <= overflow || (wr_pulse && !wr_ok);
            remain     <= (state == IDLE && tx_en) ? len : remain - CW'(commit);
            tx_start   <= state == LD;
            tx_data    <= state == LD ? ram_q : tx_data;
            busy       <= state_n != IDLE;
            send_done  <= empty_req || last;
        end
    end
endmodule

// File: tb/tb_bluetooth_send_ctrl.sv
// tb_bluetooth_send_ctrl: directed checks of frame replay, clamping, overflow and reset
module tb_bluetooth_send_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic wr_pulse = 1'b0;
    logic [7:0] rx_data = '0;
    logic tx_en = 1'b0;
    logic [15:0] data_length = '0;
    logic tx_done = 1'b0;
    logic tx_start, busy, send_done, overflow;
    logic [7:0] tx_data;
    logic [3:0] fifo_count;
    int vectors = 0;
    int miscompares = 0;
    bluetooth_send_ctrl #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .wr_pulse(wr_pulse), .rx_data(rx_data),
        .tx_en(tx_en), .data_length(data_length), .tx_done(tx_done),
        .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .send_done(send_done),
        .fifo_count(fifo_count), .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wr(input logic [7:0] b);
        wr_pulse = 1'b1;
        rx_data = b;
        tick();
        wr_pulse = 1'b0;
    endtask
    task automatic send(input logic [15:0] n);
        tx_en = 1'b1;
        data_length = n;
        tick();
        tx_en = 1'b0;
    endtask
    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask
    task automatic wait_start(input logic [7:0] exp, input int lat);
        int n = 0;
        while (!tx_start && n < 20) begin
            tick();
            n++;
        end
        chk("tx_start_latency", 16'(n), 16'(lat));
        chk("tx_start", {15'b0, tx_start}, 16'd1);
        chk("tx_data", {8'b0, tx_data}, {8'b0, exp});
    endtask
    task automatic serve(input logic [7:0] exp, input int gap);
        wait_start(exp, 2);
        repeat (gap) tick();
        chk("tx_data_hold", {8'b0, tx_data}, {8'b0, exp});
        pulse_done();
    endtask
    initial begin
        tick();
        tick();
        chk("rst_tx_start", {15'b0, tx_start}, 16'd0);
        chk("rst_busy", {15'b0, busy}, 16'd0);
        chk("rst_fifo_count", {12'b0, fifo_count}, 16'd0);
        chk("rst_overflow", {15'b0, overflow}, 16'd0);
        reset_n = 1'b1;
        tick();
        // frame of 5 with a slow transmitter
        for (int i = 1; i <= 5; i++) wr(8'(i * 8'h11));
        chk("t1_count", {12'b0, fifo_count}, 16'd5);
        send(16'd5);
        chk("t1_busy", {15'b0, busy}, 16'd1);
        for (int i = 1; i <= 5; i++) serve(8'(i * 8'h11), 20);
        chk("t1_send_done", {15'b0, send_done}, 16'd1);
        chk("t1_busy_end", {15'b0, busy}, 16'd0);
        chk("t1_count_end", {12'b0, fifo_count}, 16'd0);
        tick();
        chk("t1_send_done_1cyc", {15'b0, send_done}, 16'd0);
        // length clamped to stored bytes
        wr(8'hA1);
        wr(8'hA2);
        wr(8'hA3);
        send(16'd8);
        serve(8'hA1, 3);
        serve(8'hA2, 3);
        serve(8'hA3, 3);
        chk("t2_send_done", {15'b0, send_done}, 16'd1);
        chk("t2_count", {12'b0, fifo_count}, 16'd0);
        repeat (4) tick();
        chk("t2_no_extra_start", {15'b0, tx_start}, 16'd0);
        chk("t2_idle", {15'b0, busy}, 16'd0);
        // empty frame
        send(16'd4);
        chk("t3_send_done", {15'b0, send_done}, 16'd1);
        chk("t3_busy", {15'b0, busy}, 16'd0);
        tick();
        chk("t3_no_start", {15'b0, tx_start}, 16'd0);
        chk("t3_send_done_off", {15'b0, send_done}, 16'd0);
        // overflow at DEPTH=8
        for (int i = 1; i <= 9; i++) wr(8'(i));
        chk("t4_count_full", {12'b0, fifo_count}, 16'd8);
        chk("t4_overflow", {15'b0, overflow}, 16'd1);
        send(16'd8);
        for (int i = 1; i <= 8; i++) serve(8'(i), 2);
        chk("t4_send_done", {15'b0, send_done}, 16'd1);
        chk("t4_count_end", {12'b0, fifo_count}, 16'd0);
        chk("t4_overflow_sticky", {15'b0, overflow}, 16'd1);
        // writes and a second tx_en while a frame is in flight
        for (int i = 1; i <= 4; i++) wr(8'hB0 + 8'(i));
        send(16'd4);
        serve(8'hB1, 2);
        wait_start(8'hB2, 2);
        wr(8'hC1);
        wr(8'hC2);
        send(16'd7);
        chk("t5_tx_data_hold", {8'b0, tx_data}, 16'h00B2);
        chk("t5_count_mid", {12'b0, fifo_count}, 16'd5);
        pulse_done();
        serve(8'hB3, 2);
        serve(8'hB4, 2);
        chk("t5_send_done", {15'b0, send_done}, 16'd1);
        chk("t5_count", {12'b0, fifo_count}, 16'd2);
        tick();
        chk("t5_idle", {15'b0, busy}, 16'd0);
        send(16'd2);
        serve(8'hC1, 2);
        serve(8'hC2, 2);
        chk("t5b_send_done", {15'b0, send_done}, 16'd1);
        chk("t5b_count", {12'b0, fifo_count}, 16'd0);
        // asynchronous reset in the middle of a frame
        for (int i = 1; i <= 4; i++) wr(8'hD0 + 8'(i));
        send(16'd4);
        serve(8'hD1, 2);
        wait_start(8'hD2, 2);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_busy", {15'b0, busy}, 16'd0);
        chk("t6_tx_data", {8'b0, tx_data}, 16'd0);
        chk("t6_count", {12'b0, fifo_count}, 16'd0);
        chk("t6_overflow", {15'b0, overflow}, 16'd0);
        chk("t6_send_done", {15'b0, send_done}, 16'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6_no_send_done", {15'b0, send_done}, 16'd0);
        chk("t6_count_after", {12'b0, fifo_count}, 16'd0);
        send(16'd4);
        chk("t6_empty_done", {15'b0, send_done}, 16'd1);
        chk("t6_empty_busy", {15'b0, busy}, 16'd0);
        tick();
        chk("t6_no_start", {15'b0, tx_start}, 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
